jk_bank_arbiter: RTL and testbench

Shares one bank of WIDTH JK flip-flops between NREQ requesters. Each requester issues a single-bit JK command: hold, set, reset or toggle on a selected bit. A round-robin arbiter grants one requester per cycle and applies the winner's command to the bank on the same clock edge. The block sits between the control agents and the JK state bank, and is the only writer of that bank.

---
 rtl/jk_bank_arbiter_pkg.sv | 20 ++
 rtl/jk_bank_arbiter_if.sv | 43 ++++
 rtl/jk_rr_arbiter.sv | 40 ++++
 rtl/jk_bank_arbiter.sv | 124 ++++++++++++
 tb/tb_jk_bank_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/jk_bank_arbiter_pkg.sv
// Shared types, command encodings and helpers for the JK bank arbiter.
package jk_bank_arbiter_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_t;

  function automatic int wrap_add(int a, int b, int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Requester-side bundle for the JK bank arbiter.
// lock/locked exist only when JK_ARB_LOCK_EN is defined.
interface jk_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(WIDTH)
);

  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    jk;
  logic [SELW*NREQ-1:0] sel;
  logic [NREQ-1:0]      gnt;
  logic [WIDTH-1:0]     q;
`ifdef JK_ARB_LOCK_EN
  logic [NREQ-1:0]      lock;
  logic                 locked;
`endif

  modport master (
    output req,
    output jk,
    output sel,
`ifdef JK_ARB_LOCK_EN
    output lock,
    input  locked,
`endif
    input  gnt,
    input  q
  );

  modport slave (
    input  req,
    input  jk,
    input  sel,
`ifdef JK_ARB_LOCK_EN
    input  lock,
    output locked,
`endif
    output gnt,
    output q
  );

endinterface

// File: rtl/jk_rr_arbiter.sv
// Round-robin grant search from ptr, or forced grant to a lock owner.
module jk_rr_arbiter
  import jk_bank_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  input  logic            force_i,
  input  logic [PW-1:0]   owner_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   win_o
);

  always_comb begin
    logic found;
    int   idx;
    gnt_o = '0;
    win_o = '0;
    found = 1'b0;
    idx   = 0;
    if (force_i) begin
      if (req_i[owner_i]) begin
        gnt_o[owner_i] = 1'b1;
        win_o          = owner_i;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = wrap_add(int'(ptr_i), k, NREQ);
        if (!found && req_i[idx]) begin
          found      = 1'b1;
          gnt_o[idx] = 1'b1;
          win_o      = PW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin shared JK flip-flop bank, one bit command per cycle.
// Optional owner lock FSM enabled by JK_ARB_LOCK_EN.
module jk_bank_arbiter
  import jk_bank_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(WIDTH)
) (
  input  logic              clock,
  input  logic              clear,
  jk_bank_arbiter_if.slave  bus
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [NREQ-1:0]  gnt;
  logic [PW-1:0]    win;
  logic [PW-1:0]    owner;
  logic             force_lk;
  logic             rel;
  logic             xfer;
  logic [1:0]       jk_w;
  logic [SELW-1:0]  sel_w;

  jk_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .force_i (force_lk),
    .owner_i (owner),
    .gnt_o   (gnt),
    .win_o   (win)
  );

  assign bus.gnt = gnt;
  assign bus.q   = q_q;
  assign xfer    = |gnt;
  assign jk_w    = bus.jk[2*int'(win) +: 2];
  assign sel_w   = bus.sel[SELW*int'(win) +: SELW];

`ifdef JK_ARB_LOCK_EN
  arb_state_t    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ARB;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rel     = 1'b0;
    unique case (state_q)
      ARB: begin
        if (xfer && bus.lock[win]) begin
          state_d = LOCKED;
          owner_d = win;
        end
      end
      LOCKED: begin
        // Dropping req releases too, even without a transfer
        if (!bus.req[owner_q] ||
            (xfer && !bus.lock[owner_q])) begin
          state_d = ARB;
          rel     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    force_lk   = (state_q == LOCKED);
    owner      = owner_q;
    bus.locked = (state_q == LOCKED);
  end
`else
  assign force_lk = 1'b0;
  assign owner    = '0;
  assign rel      = 1'b0;
`endif

  always_comb begin
    ptr_d = ptr_q;
    if (xfer)
      ptr_d = PW'(wrap_add(int'(win), 1, NREQ));
    if (rel)
      ptr_d = PW'(wrap_add(int'(owner), 1, NREQ));
  end

  always_comb begin
    q_d = q_q;
    if (xfer && int'(sel_w) < WIDTH) begin
      unique case (jk_w)
        JK_SET:    q_d[sel_w] = 1'b1;
        JK_RESET:  q_d[sel_w] = 1'b0;
        JK_TOGGLE: q_d[sel_w] = ~q_q[sel_w];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      q_q   <= '0;
      ptr_q <= '0;
    end else begin
      q_q   <= q_d;
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: 8-bit bank plus a 6-bit bank
// for out-of-range selects; lock checks only with JK_ARB_LOCK_EN.
module tb_jk_bank_arbiter;
  import jk_bank_arbiter_pkg::*;

  logic clock = 1'b0;
  logic clear;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  jk_bank_arbiter_if #(.NREQ(4), .WIDTH(8)) b ();
  jk_bank_arbiter_if #(.NREQ(4), .WIDTH(6)) b2 ();

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (b)
  );

  jk_bank_arbiter #(.NREQ(4), .WIDTH(6)) dut6 (
    .clock (clock),
    .clear (clear),
    .bus   (b2)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic cmd(int i, logic [1:0] c, int s);
    logic [2:0] s3;
    s3 = 3'(s);
    b.jk[2*i +: 2]  = c;
    b.sel[3*i +: 3] = s3;
  endtask

  task automatic cmd2(int i, logic [1:0] c, int s);
    logic [2:0] s3;
    s3 = 3'(s);
    b2.jk[2*i +: 2]  = c;
    b2.sel[3*i +: 3] = s3;
  endtask

  logic [1:0] jk_seq [4];
  logic [7:0] q_seq  [4];

  initial begin
    jk_seq = '{JK_TOGGLE, JK_TOGGLE, JK_SET, JK_HOLD};
    q_seq  = '{8'h20, 8'h00, 8'h20, 8'h20};

    clear   = 1'b1;
    b.req   = 4'b1111;
    b.jk    = '0;
    b.sel   = '0;
    b2.req  = '0;
    b2.jk   = '0;
    b2.sel  = '0;
`ifdef JK_ARB_LOCK_EN
    b.lock  = '0;
    b2.lock = '0;
`endif
    for (int i = 0; i < 4; i++) cmd(i, JK_SET, i);

    tick;
    check("clr_q", 32'(b.q), 32'h00);
    tick;
    check("clr_q2", 32'(b.q), 32'h00);
    clear = 1'b0;
    #1;
    check("rst_gnt", 32'(b.gnt), 32'h1);

    for (int i = 0; i < 4; i++) begin
      check("rr_gnt", 32'(b.gnt), 32'(1 << i));
      tick;
      check("rr_q", 32'(b.q), 32'((1 << (i + 1)) - 1));
      #1;
    end

    clear = 1'b1;
    b.req = '0;
    tick;
    clear = 1'b0;
    check("jk_q0", 32'(b.q), 32'h00);
    b.req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      cmd(1, jk_seq[i], 5);
      #1;
      check("jk_gnt", 32'(b.gnt), 32'h2);
      tick;
      check("jk_q", 32'(b.q), 32'(q_seq[i]));
    end

    b.req = 4'b0011;
    cmd(0, JK_HOLD, 0);
    cmd(1, JK_RESET, 5);
    #1;
    check("hold_adv", 32'(b.gnt), 32'h1);
    tick;
    check("hold_q", 32'(b.q), 32'h20);
    b.req = 4'b0010;
    #1;
    check("rst_gnt1", 32'(b.gnt), 32'h2);
    tick;
    check("rst_q", 32'(b.q), 32'h00);

    b.req = 4'b0100;
    cmd(2, JK_HOLD, 0);
    #1;
    check("ptr2", 32'(b.gnt), 32'h4);
    tick;

    b.req = 4'b0101;
    cmd(0, JK_SET, 6);
    cmd(2, JK_SET, 7);
    #1;
    check("wrap", 32'(b.gnt), 32'h1);
    tick;
    check("wrap_q", 32'(b.q), 32'h40);
    b.req = 4'b0100;
    #1;
    check("skip", 32'(b.gnt), 32'h4);
    tick;
    check("skip_q", 32'(b.q), 32'hC0);
    b.req = 4'b1001;
    cmd(0, JK_HOLD, 0);
    cmd(3, JK_HOLD, 0);
    #1;
    check("ptr3", 32'(b.gnt), 32'h8);
    tick;
    b.req = '0;
    #1;
    check("idle", 32'(b.gnt), 32'h0);

    b2.req = 4'b0001;
    cmd2(0, JK_SET, 7);
    #1;
    check("oor_gnt", 32'(b2.gnt), 32'h1);
    tick;
    check("oor_q", 32'(b2.q), 32'h00);
    b2.req = 4'b0011;
    cmd2(0, JK_SET, 0);
    cmd2(1, JK_SET, 1);
    #1;
    check("oor_ptr", 32'(b2.gnt), 32'h2);
    tick;
    check("oor_q2", 32'(b2.q), 32'h02);
    b2.req = '0;

`ifdef JK_ARB_LOCK_EN
    clear = 1'b1;
    tick;
    clear = 1'b0;
    b.req  = 4'b0011;
    cmd(0, JK_SET, 0);
    cmd(1, JK_SET, 1);
    b.lock = 4'b0001;
    #1;
    check("lk_gnt0", 32'(b.gnt), 32'h1);
    check("lk_off", 32'(b.locked), 32'h0);
    tick;
    check("lk_on1", 32'(b.locked), 32'h1);
    #1;
    check("lk_gnt1", 32'(b.gnt), 32'h1);
    tick;
    check("lk_on2", 32'(b.locked), 32'h1);
    b.lock = '0;
    #1;
    check("lk_gnt2", 32'(b.gnt), 32'h1);
    tick;
    check("lk_rel", 32'(b.locked), 32'h0);
    #1;
    check("lk_next", 32'(b.gnt), 32'h2);

    b.req  = 4'b0001;
    b.lock = 4'b0001;
    #1;
    tick;
    check("lk_on3", 32'(b.locked), 32'h1);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    check("lk_clr", 32'(b.locked), 32'h0);
    b.req  = 4'b0011;
    b.lock = '0;
    #1;
    check("lk_clr_ptr", 32'(b.gnt), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
